// File: rtl/seek_initiator.sv
// Drives 2310 access strobes (GO/REV/10_20) to seek an absolute cylinder or to recalibrate
// to home, pacing each step on the drive's ACCESS_RDY handshake.
`timescale 1ns/1ps
module seek_initiator #(
  parameter int SETUP_US   = 2,
  parameter int GO_US      = 10,
  parameter int RDY_TMO_US = 20000,
  parameter int MAX_CYL    = 202
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clkenbl_1usec,
  input  logic       seek_start,
  input  logic       recal_start,
  input  logic [7:0] target_cyl,
  input  logic       BUS_ACCESS_RDY_H,
  input  logic       BUS_HOME_L,
  output logic       BUS_ACC_GO_L,
  output logic       BUS_ACC_REV_L,
  output logic       BUS_10_20_L,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] current_cyl
);

  localparam int                TMR_W       = $clog2(RDY_TMO_US + 1);
  localparam logic [TMR_W-1:0]  SETUP_END   = TMR_W'(SETUP_US - 1);
  localparam logic [TMR_W-1:0]  GO_END      = TMR_W'(GO_US - 1);
  localparam logic [TMR_W-1:0]  TMO_END     = TMR_W'(RDY_TMO_US - 1);
  localparam logic [7:0]        MAX_CYL_C   = 8'(MAX_CYL);
  localparam logic [6:0]        RECAL_LIMIT = 7'(MAX_CYL / 2 + 2);

  typedef enum logic [2:0] {
    IDLE, PLAN, SETUP, GO, WAIT_DROP, WAIT_RISE, DONE, ERR
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       rdy_sync_q, home_sync_q;
  logic             rdy_s, home_l_s;
  logic             recal_q, recal_d;
  logic [7:0]       target_q, target_d;
  logic [7:0]       cyl_q, cyl_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [6:0]       recal_steps_q, recal_steps_d;
  logic             go_l_q, rev_l_q, rev_l_d, step2_q, step2_d, error_q, error_d;
  logic [7:0]       diff, stepped_cyl;
  logic [8:0]       step9, sum9;

  assign rdy_s    = rdy_sync_q[2];
  assign home_l_s = home_sync_q[2];

  // Arm position after the step just completed, clamped to the legal cylinder range.
  always_comb begin
    step9 = step2_q ? 9'd2 : 9'd1;
    if (rev_l_q) begin
      sum9        = {1'b0, cyl_q} + step9;
      stepped_cyl = (sum9 > {1'b0, MAX_CYL_C}) ? MAX_CYL_C : sum9[7:0];
    end else begin
      sum9        = {1'b0, cyl_q} - step9;
      stepped_cyl = sum9[8] ? 8'd0 : sum9[7:0];
    end
    diff = (target_q > cyl_q) ? (target_q - cyl_q) : (cyl_q - target_q);
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    recal_d       = recal_q;
    target_d      = target_q;
    cyl_d         = cyl_q;
    tmr_d         = tmr_q;
    recal_steps_d = recal_steps_q;
    rev_l_d       = rev_l_q;
    step2_d       = step2_q;
    error_d       = error_q;

    case (state_q)
      IDLE: begin
        if (seek_start) begin
          recal_d  = 1'b0;
          target_d = target_cyl;
          error_d  = 1'b0;
          state_d  = PLAN;
        end else if (recal_start) begin
          recal_d       = 1'b1;
          recal_steps_d = '0;
          error_d       = 1'b0;
          state_d       = PLAN;
        end
      end
      PLAN: begin
        tmr_d = '0;
        if (recal_q) begin
          if (!home_l_s) begin
            cyl_d   = 8'd0;
            state_d = DONE;
          end else if (recal_steps_q > RECAL_LIMIT) begin
            state_d = ERR;
          end else begin
            rev_l_d = 1'b0;
            step2_d = 1'b1;
            state_d = SETUP;
          end
        end else if (target_q > MAX_CYL_C) begin
          state_d = ERR;
        end else if (target_q == cyl_q) begin
          state_d = DONE;
        end else begin
          rev_l_d = (target_q > cyl_q);
          step2_d = (diff >= 8'd2);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (clkenbl_1usec) begin
          if (tmr_q == SETUP_END) begin
            tmr_d   = '0;
            state_d = GO;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      GO: begin
        if (clkenbl_1usec) begin
          if (tmr_q == GO_END) begin
            tmr_d   = '0;
            state_d = WAIT_DROP;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      WAIT_DROP: begin
        if (!rdy_s) begin
          tmr_d   = '0;
          state_d = WAIT_RISE;
        end else if (clkenbl_1usec) begin
          if (tmr_q == TMO_END) state_d = ERR;
          else                  tmr_d   = tmr_q + TMR_W'(1);
        end
      end
      WAIT_RISE: begin
        if (rdy_s) begin
          cyl_d = stepped_cyl;
          if (recal_q) recal_steps_d = recal_steps_q + 7'd1;
          // A reverse step that lands on home resynchronises the estimate; in seek mode an
          // estimate of zero without HOME means the tracked position has drifted.
          if (!rev_l_q && !home_l_s) cyl_d = 8'd0;
          if (!rev_l_q && !recal_q && home_l_s && (stepped_cyl == 8'd0)) state_d = ERR;
          else                                                           state_d = PLAN;
        end else if (clkenbl_1usec) begin
          if (tmr_q == TMO_END) state_d = ERR;
          else                  tmr_d   = tmr_q + TMR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == ERR) error_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rdy_sync_q    <= 3'b111;
      home_sync_q   <= 3'b111;
      recal_q       <= 1'b0;
      target_q      <= 8'd0;
      cyl_q         <= 8'd0;
      tmr_q         <= '0;
      recal_steps_q <= '0;
      go_l_q        <= 1'b1;
      rev_l_q       <= 1'b1;
      step2_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdy_sync_q    <= {rdy_sync_q[1:0], BUS_ACCESS_RDY_H};
      home_sync_q   <= {home_sync_q[1:0], BUS_HOME_L};
      recal_q       <= recal_d;
      target_q      <= target_d;
      cyl_q         <= cyl_d;
      tmr_q         <= tmr_d;
      recal_steps_q <= recal_steps_d;
      go_l_q        <= (state_d != GO);
      rev_l_q       <= rev_l_d;
      step2_q       <= step2_d;
      error_q       <= error_d;
    end
  end

  assign BUS_ACC_GO_L  = go_l_q;
  assign BUS_ACC_REV_L = rev_l_q;
  assign BUS_10_20_L   = step2_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign error         = error_q;
  assign current_cyl   = cyl_q;

endmodule
